// File: rtl/flush_redirect_ctrl_if.sv
// Signal bundle between the flush/redirect sequencer and the WB/CSR/IF side.
// master = sequencer, slave = pipeline side.
interface flush_redirect_ctrl_if;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic        ertn_flush;
  logic        wb_refetch_flush;
  logic [31:0] wb_pc;
  logic [31:0] csr_eentry;
  logic [31:0] csr_tlbrentry;
  logic [31:0] csr_era;
  logic        inst_req_hs;
  logic        inst_data_ok;
  logic        flush;
  logic        busy;
  logic        discard;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    input  wb_ex, wb_ecode, ertn_flush, wb_refetch_flush, wb_pc,
    input  csr_eentry, csr_tlbrentry, csr_era,
    input  inst_req_hs, inst_data_ok, redirect_ready,
    output flush, busy, discard, redirect_valid, redirect_pc
  );

  modport slave (
    output wb_ex, wb_ecode, ertn_flush, wb_refetch_flush, wb_pc,
    output csr_eentry, csr_tlbrentry, csr_era,
    output inst_req_hs, inst_data_ok, redirect_ready,
    input  flush, busy, discard, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/flush_redirect_ctrl.sv
// Flush/redirect sequencer: captures WB exception/ertn/refetch, flushes the pipe,
// drains stale inst-SRAM responses, then holds the redirect PC until accepted.
module flush_redirect_ctrl #(
  parameter int unsigned OUTST_W     = 2,
  parameter logic [31:0] REFETCH_OFS = 32'd4
) (
  input  logic                  clk,
  input  logic                  resetn,
  flush_redirect_ctrl_if.master fr
);

  localparam logic [5:0]         ECODE_TLBR = 6'h3F;
  localparam logic [OUTST_W-1:0] OUTST_MAX  = '1;
  localparam logic [OUTST_W-1:0] OUTST_ONE  = OUTST_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_DRAIN,
    S_REDIR
  } state_t;

  state_t               state, state_nxt;
  logic [OUTST_W-1:0]   outst_cnt, outst_nxt;
  logic [OUTST_W-1:0]   drain_cnt, drain_nxt;
  logic [31:0]          target, target_nxt, target_sel;
  logic                 event_any;

  logic                 flush_o, busy_o, discard_o, rv_o;
  logic [31:0]          rpc_o;

  assign event_any = fr.wb_ex | fr.ertn_flush | fr.wb_refetch_flush;

  always_comb begin
    if (fr.wb_ex) begin
      target_sel = (fr.wb_ecode == ECODE_TLBR) ? fr.csr_tlbrentry : fr.csr_eentry;
    end else if (fr.ertn_flush) begin
      target_sel = fr.csr_era;
    end else begin
      target_sel = fr.wb_pc + REFETCH_OFS;
    end
  end

  // Saturating in-flight counter; a simultaneous request and response cancel out.
  always_comb begin
    outst_nxt = outst_cnt;
    if (fr.inst_req_hs && !fr.inst_data_ok && outst_cnt != OUTST_MAX) begin
      outst_nxt = outst_cnt + OUTST_ONE;
    end else if (fr.inst_data_ok && !fr.inst_req_hs && outst_cnt != '0) begin
      outst_nxt = outst_cnt - OUTST_ONE;
    end
  end

  always_comb begin
    state_nxt  = state;
    drain_nxt  = drain_cnt;
    target_nxt = target;
    flush_o    = 1'b0;
    busy_o     = 1'b0;
    discard_o  = 1'b0;
    rv_o       = 1'b0;
    rpc_o      = '0;
    case (state)
      S_IDLE: begin
        if (event_any) begin
          state_nxt  = S_FLUSH;
          target_nxt = target_sel;
          drain_nxt  = outst_nxt;
        end
      end
      S_FLUSH: begin
        flush_o   = 1'b1;
        busy_o    = 1'b1;
        state_nxt = (drain_cnt != '0) ? S_DRAIN : S_REDIR;
      end
      S_DRAIN: begin
        busy_o    = 1'b1;
        discard_o = fr.inst_data_ok;
        if (fr.inst_data_ok) begin
          if (drain_cnt > OUTST_ONE) begin
            drain_nxt = drain_cnt - OUTST_ONE;
          end else begin
            drain_nxt = '0;
            state_nxt = S_REDIR;
          end
        end
      end
      S_REDIR: begin
        busy_o = 1'b1;
        rv_o   = 1'b1;
        rpc_o  = target;
        if (fr.redirect_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      outst_cnt <= '0;
      drain_cnt <= '0;
      target    <= '0;
    end else begin
      state     <= state_nxt;
      outst_cnt <= outst_nxt;
      drain_cnt <= drain_nxt;
      target    <= target_nxt;
    end
  end

  assign fr.flush          = flush_o;
  assign fr.busy           = busy_o;
  assign fr.discard        = discard_o;
  assign fr.redirect_valid = rv_o;
  assign fr.redirect_pc    = rpc_o;

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Bench for flush_redirect_ctrl: vector table, directed multi-cycle sequences,
// and randomized traffic against a transaction-level reference model.
module tb_flush_redirect_ctrl;

  localparam logic [31:0] EENTRY = 32'h1C00_8000;
  localparam logic [31:0] TLBRE  = 32'h1C00_F000;
  localparam logic [31:0] ERA    = 32'h1C00_0100;
  localparam int          OMAX   = 3;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flush_redirect_ctrl_if bus ();

  flush_redirect_ctrl #(.OUTST_W(2), .REFETCH_OFS(32'd4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .fr     (bus)
  );

  typedef struct {
    logic        ex;
    logic [5:0]  ecode;
    logic        ertn;
    logic        rf;
    logic [31:0] pc;
    logic        req;
    logic        ok;
    logic        rdy;
    logic        e_flush;
    logic        e_busy;
    logic        e_disc;
    logic        e_rv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic f, input logic b, input logic d,
                         input logic rv, input logic [31:0] pc);
    chk({nm, ".flush"},   32'(bus.flush),          32'(f));
    chk({nm, ".busy"},    32'(bus.busy),           32'(b));
    chk({nm, ".discard"}, 32'(bus.discard),        32'(d));
    chk({nm, ".rvalid"},  32'(bus.redirect_valid), 32'(rv));
    chk({nm, ".rpc"},     bus.redirect_pc,         pc);
  endtask

  task automatic drive(input logic ex, input logic [5:0] ecode, input logic ertn,
                       input logic rf, input logic [31:0] pc, input logic req,
                       input logic ok, input logic rdy);
    bus.wb_ex            = ex;
    bus.wb_ecode         = ecode;
    bus.ertn_flush       = ertn;
    bus.wb_refetch_flush = rf;
    bus.wb_pc            = pc;
    bus.inst_req_hs      = req;
    bus.inst_data_ok     = ok;
    bus.redirect_ready   = rdy;
  endtask

  // Advance to just after the next rising edge, apply inputs, then wait for the sample point.
  task automatic step(input logic ex, input logic [5:0] ecode, input logic ertn,
                      input logic rf, input logic [31:0] pc, input logic req,
                      input logic ok, input logic rdy);
    @(posedge clk);
    #1;
    drive(ex, ecode, ertn, rf, pc, req, ok, rdy);
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reference model: outstanding count, remaining stale responses, and pending work.
  int          m_outst;
  int          m_drain;
  bit          m_active;
  bit          m_flush_due;
  logic [31:0] m_tgt;

  task automatic model_update();
    int nxt;
    nxt = m_outst + int'(bus.inst_req_hs) - int'(bus.inst_data_ok);
    if (nxt < 0)    nxt = 0;
    if (nxt > OMAX) nxt = OMAX;
    if (!m_active) begin
      if (bus.wb_ex || bus.ertn_flush || bus.wb_refetch_flush) begin
        m_active    = 1'b1;
        m_flush_due = 1'b1;
        m_drain     = nxt;
        if (bus.wb_ex)           m_tgt = (bus.wb_ecode == 6'h3F) ? bus.csr_tlbrentry : bus.csr_eentry;
        else if (bus.ertn_flush) m_tgt = bus.csr_era;
        else                     m_tgt = bus.wb_pc + 32'd4;
      end
    end else if (m_flush_due) begin
      m_flush_due = 1'b0;
    end else if (m_drain > 0) begin
      if (bus.inst_data_ok) m_drain--;
    end else if (bus.redirect_ready) begin
      m_active = 1'b0;
    end
    m_outst = nxt;
  endtask

  task automatic model_check(input int cyc);
    logic e_rv;
    e_rv = m_active && !m_flush_due && (m_drain == 0);
    chk($sformatf("rand%0d", cyc), 32'(bus.flush), 32'(m_flush_due));
    chk($sformatf("rand%0d.busy", cyc), 32'(bus.busy), 32'(m_active));
    chk($sformatf("rand%0d.discard", cyc), 32'(bus.discard),
        32'(m_active && !m_flush_due && m_drain > 0 && bus.inst_data_ok));
    chk($sformatf("rand%0d.rvalid", cyc), 32'(bus.redirect_valid), 32'(e_rv));
    chk($sformatf("rand%0d.rpc", cyc), bus.redirect_pc, e_rv ? m_tgt : 32'h0);
  endtask

  initial begin
    //           ex  ecode  ertn rf  pc            req  ok   rdy  fl   bsy  dsc  rv   rpc
    vecs[0]  = '{1'b1, 6'h0B, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, EENTRY};
    vecs[3]  = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 6'h3F, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, TLBRE};
    vecs[7]  = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, TLBRE};
    vecs[8]  = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 6'h00, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 6'h00, 1'b1, 1'b1, 32'h1000,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ERA};
    vecs[16] = '{1'b0, 6'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    resetn = 1'b0;
    drive(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    bus.csr_eentry    = EENTRY;
    bus.csr_tlbrentry = TLBRE;
    bus.csr_era       = ERA;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    resetn = 1'b1;

    for (int unsigned i = 0; i < 17; i++) begin
      step(vecs[i].ex, vecs[i].ecode, vecs[i].ertn, vecs[i].rf, vecs[i].pc,
           vecs[i].req, vecs[i].ok, vecs[i].rdy);
      chk_out($sformatf("vec%0d", i), vecs[i].e_flush, vecs[i].e_busy,
              vecs[i].e_disc, vecs[i].e_rv, vecs[i].e_pc);
    end

    // Two outstanding requests drained; responses at N+3 and N+5.
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6'h0B, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_out("drn_n0", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_step();
    chk_out("drn_n1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    idle_step();
    chk_out("drn_n2", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk_out("drn_n3", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    idle_step();
    chk_out("drn_n4", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk_out("drn_n5", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_out("drn_n6", 1'b0, 1'b1, 1'b0, 1'b1, EENTRY);
    idle_step();
    chk_out("drn_n7", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Request handshake in the event cycle counts toward the drain.
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle_step();
    chk_out("sc_n1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk_out("sc_n2", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk_out("sc_n3", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_out("sc_n4", 1'b0, 1'b1, 1'b0, 1'b1, ERA);
    idle_step();
    chk_out("sc_n5", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Backpressure: pc held, a new exception while busy is ignored.
    step(1'b0, 6'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle_step();
    chk_out("bp_flush", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    bus.csr_eentry = 32'h1C00_9000;
    for (int unsigned k = 0; k < 5; k++) begin
      step(k == 1, 6'h0B, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk_out($sformatf("bp_hold%0d", k), 1'b0, 1'b1, 1'b0, 1'b1, ERA);
    end
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_out("bp_acc", 1'b0, 1'b1, 1'b0, 1'b1, ERA);
    idle_step();
    chk_out("bp_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    bus.csr_eentry = EENTRY;

    // Reset in the middle of a drain clears state and the outstanding count.
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6'h0B, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle_step();
    chk_out("rst_flush", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    idle_step();
    chk_out("rst_drain", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    bus.inst_data_ok = 1'b1;
    resetn = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(1'b1, 6'h0B, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("rst_ev", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_step();
    chk_out("rst_fl", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 6'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_out("rst_rv", 1'b0, 1'b1, 1'b0, 1'b1, EENTRY);
    idle_step();
    chk_out("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Randomized traffic from a clean reset.
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    m_outst     = 0;
    m_drain     = 0;
    m_active    = 1'b0;
    m_flush_due = 1'b0;
    m_tgt       = 32'h0;
    @(posedge clk);
    for (int c = 0; c < 2000; c++) begin
      #1;
      bus.csr_eentry    = $urandom;
      bus.csr_tlbrentry = $urandom;
      bus.csr_era       = $urandom;
      drive(($urandom % 20) == 0,
            (($urandom % 4) == 0) ? 6'h3F : 6'($urandom),
            ($urandom % 20) == 0,
            ($urandom % 20) == 0,
            (($urandom % 8) == 0) ? 32'hFFFFFFFC : $urandom,
            !m_active && (($urandom % 3) == 0),
            (m_outst > 0) ? (($urandom % 3) == 0) : (($urandom % 16) == 0),
            ($urandom % 2) == 0);
      @(negedge clk);
      model_check(c);
      @(posedge clk);
      model_update();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
